ps2_scancode_rx: RTL



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_clk_filter.sv | 47 ++++
 rtl/ps2_scancode_rx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int PS2_FRAME_LEN = 11;

  // Odd parity holds when the data byte plus parity bit carry an odd ones-count.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 pins, debounces ps2_clk and flags filtered falling edges.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic [CW-1:0]          cnt;
  logic                   filt;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      cnt      <= '0;
      filt     <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data};
      clk_fall <= 1'b0;
      if (clk_sr[SYNC_STAGES-1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt     <= clk_sr[SYNC_STAGES-1];
        cnt      <= '0;
        clk_fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_sync = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver folding E0/F0 prefixes into flags.
// Optional frame timeout is built when PS2_TIMEOUT_EN is defined.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       break_code,
  output logic       parity_err,
  output logic       frame_err
);

  logic       clk_fall;
  logic       data_sync;
  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       ext_pending;
  logic       brk_pending;
  logic       timeout;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_fall (clk_fall),
    .data_sync(data_sync)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE || clk_fall || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !clk_fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      code_valid  <= 1'b0;
      scan_code   <= '0;
      extended    <= 1'b0;
      break_code  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (clk_fall) begin
        unique case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {data_sync, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_sync || !parity_ok(shreg, par_bit)) begin
              parity_err  <= !parity_ok(shreg, par_bit);
              frame_err   <= !data_sync;
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              ext_pending <= 1'b1;
            end else if (shreg == PS2_BRK) begin
              brk_pending <= 1'b1;
            end else if (shreg == PS2_PAUSE) begin
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end else begin
              code_valid  <= 1'b1;
              scan_code   <= shreg;
              extended    <= ext_pending;
              break_code  <= brk_pending;
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state       <= IDLE;
        frame_err   <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end
    end
  end

endmodule
